// File: rtl/aes_gcm_pkg.sv
// aes_gcm_pkg
// Shared definitions for the AES-GCM job sequencer and the pipeline stages
// it feeds: pipeline phase codes, the sequencer FSM state encoding and the
// GCM length-block packing helper.
package aes_gcm_pkg;

    typedef logic [2:0] phase_t;

    // Phase codes seen by the pipeline. The counter stage reloads on
    // PH_INIT/PH_IDLE, holds on PH_HOLD and increments on anything else.
    localparam phase_t PH_IDLE = 3'b000;
    localparam phase_t PH_AAD  = 3'b001;
    localparam phase_t PH_TEXT = 3'b010;
    localparam phase_t PH_LEN  = 3'b011;
    localparam phase_t PH_HOLD = 3'b100;
    localparam phase_t PH_INIT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_AAD,
        ST_TEXT,
        ST_LEN,
        ST_DRAIN
    } seq_state_e;

    // GCM length block: bit lengths of AAD (upper half) and text (lower
    // half). Each block is 128 bits, so the bit length is the count << 7.
    function automatic logic [127:0] pack_len(input logic [63:0] aad_blocks,
                                              input logic [63:0] text_blocks);
        return {aad_blocks << 7, text_blocks << 7};
    endfunction

endpackage

// File: rtl/aes_gcm_sequencer_if.sv
// aes_gcm_sequencer_if
// Bundles the source block stream (valid/ready/data) and the pipeline issue
// bus driven by the sequencer.
//   master : the sequencer (consumes blocks, drives the pipeline inputs)
//   slave  : the environment (block source and first pipeline stage)
interface aes_gcm_sequencer_if;
    import aes_gcm_pkg::*;

    logic         i_blk_valid;
    logic [127:0] i_blk_data;
    logic         o_blk_ready;
    logic         o_valid;
    phase_t       o_phase;
    logic [95:0]  o_iv;
    logic [127:0] o_aad;
    logic [127:0] o_plain_text;
    logic [127:0] o_instance_size;

    modport master (
        input  i_blk_valid, i_blk_data,
        output o_blk_ready, o_valid, o_phase, o_iv, o_aad, o_plain_text,
               o_instance_size
    );

    modport slave (
        output i_blk_valid, i_blk_data,
        input  o_blk_ready, o_valid, o_phase, o_iv, o_aad, o_plain_text,
               o_instance_size
    );

endinterface

// File: rtl/aes_gcm_drain_timer.sv
// aes_gcm_drain_timer
// Loadable down-counter that waits out the pipeline latency after the LEN
// issue and produces a one-cycle done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load PIPE_LATENCY (asserted in the cycle that registers LEN)
//   done       : registered pulse, PIPE_LATENCY cycles after the LEN issue
module aes_gcm_drain_timer #(
    parameter int PIPE_LATENCY = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    localparam int TW = $clog2(PIPE_LATENCY + 1);

    logic [TW-1:0] cnt;

    // The count reads PIPE_LATENCY in the LEN issue cycle; the pulse is
    // registered off cnt==1, so it lands exactly PIPE_LATENCY cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= (cnt == TW'(1));
            if (load) begin
                cnt <= TW'(PIPE_LATENCY);
            end else if (cnt != '0) begin
                cnt <= cnt - TW'(1);
            end
        end
    end

endmodule

// File: rtl/aes_gcm_sequencer.sv
// aes_gcm_sequencer
// Job-level controller for the AES-GCM encryption pipeline. Accepts a job
// (IV, AAD block count, text block count), streams AAD then plaintext blocks
// from a valid/ready source into the pipeline one issue per cycle, issues the
// length block, waits out the pipeline latency and pulses o_done.
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_start          : job request, accepted only while o_busy=0
//   i_iv             : 96-bit IV, captured on accept
//   i_aad_blocks     : AAD block count, captured on accept
//   i_text_blocks    : plaintext block count, captured on accept
//   bus (master)     : block stream in, registered pipeline issue bus out
//   o_busy           : job in progress (INIT issue cycle through o_done)
//   o_done           : one-cycle completion pulse
module aes_gcm_sequencer
    import aes_gcm_pkg::*;
#(
    parameter int PIPE_LATENCY = 12,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [95:0]          i_iv,
    input  logic [CNT_W-1:0]     i_aad_blocks,
    input  logic [CNT_W-1:0]     i_text_blocks,
    output logic                 o_busy,
    output logic                 o_done,
    aes_gcm_sequencer_if.master  bus
);

    seq_state_e       state, state_nxt;
    logic [CNT_W-1:0] aad_tot, aad_tot_nxt;
    logic [CNT_W-1:0] text_tot, text_tot_nxt;
    logic [CNT_W-1:0] aad_left, aad_left_nxt;
    logic [CNT_W-1:0] text_left, text_left_nxt;
    logic             blk_ready;
    logic             blk_hs;
    logic             timer_load;
    logic             timer_done;

    // Issue computed this cycle (p0) and the registered issue on the bus (p1).
    logic             vld_p0, vld_p1;
    phase_t           phase_p0, phase_p1;
    logic [95:0]      iv_p0, iv_p1;
    logic [127:0]     aad_p0, aad_p1;
    logic [127:0]     pt_p0, pt_p1;
    logic [127:0]     len_p0, len_p1;

    assign blk_ready = (state == ST_AAD) || (state == ST_TEXT);
    assign blk_hs    = blk_ready && bus.i_blk_valid;

    // The INIT issue is computed in the start-accept cycle, and the FSM lands
    // directly on INIT's successor. That way the first AAD/TEXT block can be
    // handshaken while INIT sits on the outputs, keeping issues back-to-back.
    always_comb begin
        state_nxt     = state;
        aad_tot_nxt   = aad_tot;
        text_tot_nxt  = text_tot;
        aad_left_nxt  = aad_left;
        text_left_nxt = text_left;
        timer_load    = 1'b0;
        vld_p0        = 1'b0;
        phase_p0      = PH_IDLE;
        iv_p0         = iv_p1;
        aad_p0        = '0;
        pt_p0         = '0;
        len_p0        = '0;

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    aad_tot_nxt   = i_aad_blocks;
                    text_tot_nxt  = i_text_blocks;
                    aad_left_nxt  = i_aad_blocks;
                    text_left_nxt = i_text_blocks;
                    iv_p0         = i_iv;
                    vld_p0        = 1'b1;
                    phase_p0      = PH_INIT;
                    if (i_aad_blocks != '0) begin
                        state_nxt = ST_AAD;
                    end else if (i_text_blocks != '0) begin
                        state_nxt = ST_TEXT;
                    end else begin
                        state_nxt = ST_LEN;
                    end
                end
            end

            ST_AAD: begin
                if (blk_hs) begin
                    vld_p0       = 1'b1;
                    phase_p0     = PH_AAD;
                    aad_p0       = bus.i_blk_data;
                    aad_left_nxt = aad_left - CNT_W'(1);
                    if (aad_left == CNT_W'(1)) begin
                        state_nxt = (text_tot != '0) ? ST_TEXT : ST_LEN;
                    end
                end else begin
                    phase_p0 = PH_HOLD;
                end
            end

            ST_TEXT: begin
                if (blk_hs) begin
                    vld_p0        = 1'b1;
                    phase_p0      = PH_TEXT;
                    pt_p0         = bus.i_blk_data;
                    text_left_nxt = text_left - CNT_W'(1);
                    if (text_left == CNT_W'(1)) begin
                        state_nxt = ST_LEN;
                    end
                end else begin
                    phase_p0 = PH_HOLD;
                end
            end

            ST_LEN: begin
                vld_p0     = 1'b1;
                phase_p0   = PH_LEN;
                len_p0     = pack_len(64'(aad_tot), 64'(text_tot));
                timer_load = 1'b1;
                state_nxt  = ST_DRAIN;
            end

            ST_DRAIN: begin
                // o_done and o_busy share the final cycle; the IV clears as
                // the FSM returns to idle.
                if (timer_done) begin
                    state_nxt = ST_IDLE;
                    iv_p0     = '0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                iv_p0     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            aad_tot   <= '0;
            text_tot  <= '0;
            aad_left  <= '0;
            text_left <= '0;
        end else begin
            state     <= state_nxt;
            aad_tot   <= aad_tot_nxt;
            text_tot  <= text_tot_nxt;
            aad_left  <= aad_left_nxt;
            text_left <= text_left_nxt;
        end
    end

    // ---- issue register: p0 -> p1 (pipeline-facing outputs) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            phase_p1 <= PH_IDLE;
            iv_p1    <= '0;
            aad_p1   <= '0;
            pt_p1    <= '0;
            len_p1   <= '0;
        end else begin
            vld_p1   <= vld_p0;
            phase_p1 <= phase_p0;
            iv_p1    <= iv_p0;
            aad_p1   <= aad_p0;
            pt_p1    <= pt_p0;
            len_p1   <= len_p0;
        end
    end

    aes_gcm_drain_timer #(
        .PIPE_LATENCY (PIPE_LATENCY)
    ) u_drain_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .done  (timer_done)
    );

    assign bus.o_blk_ready     = blk_ready;
    assign bus.o_valid         = vld_p1;
    assign bus.o_phase         = phase_p1;
    assign bus.o_iv            = iv_p1;
    assign bus.o_aad           = aad_p1;
    assign bus.o_plain_text    = pt_p1;
    assign bus.o_instance_size = len_p1;
    assign o_busy              = (state != ST_IDLE);
    assign o_done              = timer_done;

endmodule

// File: tb/tb_aes_gcm_sequencer.sv
// tb_aes_gcm_sequencer
// Scoreboard bench: each job pushes its expected issue sequence, a negedge
// monitor pops and compares every issue, checks idle/stall cycles, and checks
// the LEN-to-done latency.
module tb_aes_gcm_sequencer;

    localparam int PL    = 12;
    localparam int CNT_W = 16;

    localparam logic [2:0] P_IDLE = 3'b000;
    localparam logic [2:0] P_AAD  = 3'b001;
    localparam logic [2:0] P_TEXT = 3'b010;
    localparam logic [2:0] P_LEN  = 3'b011;
    localparam logic [2:0] P_HOLD = 3'b100;
    localparam logic [2:0] P_INIT = 3'b111;

    typedef struct packed {
        logic [2:0]   ph;
        logic [95:0]  iv;
        logic [127:0] aad;
        logic [127:0] pt;
        logic [127:0] len;
    } issue_t;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [95:0]      i_iv;
    logic [CNT_W-1:0] i_aad_blocks;
    logic [CNT_W-1:0] i_text_blocks;
    logic             o_busy;
    logic             o_done;

    aes_gcm_sequencer_if bus ();

    aes_gcm_sequencer #(
        .PIPE_LATENCY (PL),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_iv          (i_iv),
        .i_aad_blocks  (i_aad_blocks),
        .i_text_blocks (i_text_blocks),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .bus           (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          init_cyc = -1;
    int          len_cyc = -1;
    bit          len_pending = 0;
    int          hold_seen = 0;
    int          done_seen = 0;
    logic [95:0] cur_iv = '0;
    issue_t      sb[$];
    issue_t      act_i;
    issue_t      exp_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic issue_t mk(input logic [2:0] ph, input logic [95:0] iv,
                                  input logic [127:0] aad, input logic [127:0] pt,
                                  input logic [127:0] len);
        issue_t r;
        r.ph  = ph;
        r.iv  = iv;
        r.aad = aad;
        r.pt  = pt;
        r.len = len;
        return r;
    endfunction

    function automatic logic [127:0] blk(input int k);
        return {32'hB10C_0000 + 32'(k), ~32'(k), 32'h1234_5678, 32'(k)};
    endfunction

    // ---- monitor ----
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_valid) begin
                act_i = mk(bus.o_phase, bus.o_iv, bus.o_aad, bus.o_plain_text,
                           bus.o_instance_size);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue: got ph=%b iv=%h with nothing queued",
                             act_i.ph, act_i.iv);
                end else begin
                    exp_i = sb.pop_front();
                    if (act_i !== exp_i) begin
                        errors++;
                        $display("FAIL issue: got ph=%b iv=%h aad=%h pt=%h len=%h, expected ph=%b iv=%h aad=%h pt=%h len=%h",
                                 act_i.ph, act_i.iv, act_i.aad, act_i.pt, act_i.len,
                                 exp_i.ph, exp_i.iv, exp_i.aad, exp_i.pt, exp_i.len);
                    end
                end
                chk_int("busy_on_issue", int'(o_busy), 1);
                if (bus.o_phase == P_INIT) init_cyc = cyc;
                if (bus.o_phase == P_LEN) begin
                    len_cyc     = cyc;
                    len_pending = 1'b1;
                end
            end else begin
                if (bus.o_phase == P_HOLD) hold_seen++;
                checks++;
                if ((bus.o_phase != P_IDLE && bus.o_phase != P_HOLD) ||
                    bus.o_aad != '0 || bus.o_plain_text != '0 ||
                    bus.o_instance_size != '0 ||
                    bus.o_iv != (o_busy ? cur_iv : 96'h0)) begin
                    errors++;
                    $display("FAIL quiet_cycle: got ph=%b iv=%h aad=%h pt=%h len=%h busy=%b",
                             bus.o_phase, bus.o_iv, bus.o_aad, bus.o_plain_text,
                             bus.o_instance_size, o_busy);
                end
            end
            if (o_done) begin
                done_seen++;
                checks++;
                if (!len_pending || (cyc - len_cyc) != PL) begin
                    errors++;
                    $display("FAIL done_latency: got %0d cycles after LEN (pending=%0d) expected %0d",
                             cyc - len_cyc, len_pending, PL);
                end
                len_pending = 1'b0;
                chk_int("busy_on_done", int'(o_busy), 1);
            end
        end
    end

    task automatic run_job(input string tag, input logic [95:0] iv, input int a,
                           input int t, input logic [127:0] exp_len, input bit stall,
                           input bit noisy, input int exp_holds);
        int sent;
        int n;
        int hold0;
        int done0;
        int acc_cyc;
        bit hs;
        cur_iv = iv;
        sb.push_back(mk(P_INIT, iv, '0, '0, '0));
        for (int k = 0; k < a; k++) sb.push_back(mk(P_AAD, iv, blk(k), '0, '0));
        for (int k = 0; k < t; k++) sb.push_back(mk(P_TEXT, iv, '0, blk(a + k), '0));
        sb.push_back(mk(P_LEN, iv, '0, '0, exp_len));
        hold0 = hold_seen;
        done0 = done_seen;
        chk_int({tag, "_idle_before_start"}, int'(o_busy), 0);

        i_start       = 1'b1;
        i_iv          = iv;
        i_aad_blocks  = 16'(a);
        i_text_blocks = 16'(t);
        @(posedge clk); #1;
        acc_cyc       = cyc;
        i_start       = 1'b0;
        i_iv          = 96'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
        i_aad_blocks  = 16'hFFFF;
        i_text_blocks = 16'hFFFF;

        sent = 0;
        n    = 0;
        while (sent < a + t && n < 2 * (a + t) + 8) begin
            bus.i_blk_valid = stall ? (n % 2 == 0) : 1'b1;
            bus.i_blk_data  = blk(sent);
            i_start         = noisy && (n == 1);
            hs              = bus.o_blk_ready && bus.i_blk_valid;
            @(posedge clk); #1;
            if (hs) sent++;
            n++;
        end
        i_start = 1'b0;
        chk_int({tag, "_blocks_accepted"}, sent, a + t);

        bus.i_blk_valid = noisy;
        bus.i_blk_data  = noisy ? 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF : '0;
        n = 0;
        while (done_seen == done0 && n < PL + 16) begin
            @(posedge clk); #1;
            n++;
        end
        bus.i_blk_valid = 1'b0;
        bus.i_blk_data  = '0;

        chk_int({tag, "_done_count"}, done_seen - done0, 1);
        chk_int({tag, "_issues_left"}, sb.size(), 0);
        chk_int({tag, "_init_cycle"}, init_cyc, acc_cyc);
        if (!stall) chk_int({tag, "_len_cycle"}, len_cyc - init_cyc, a + t + 1);
        chk_int({tag, "_hold_cycles"}, hold_seen - hold0, exp_holds);
        sb.delete();
    endtask

    initial begin
        int done0;
        bit hs;
        int sent;
        rst_n           = 1'b1;
        i_start         = 1'b0;
        i_iv            = '0;
        i_aad_blocks    = '0;
        i_text_blocks   = '0;
        bus.i_blk_valid = 1'b0;
        bus.i_blk_data  = '0;
        #1 rst_n = 1'b0;

        @(negedge clk);
        chk_int("rst_valid", int'(bus.o_valid), 0);
        chk_int("rst_phase", int'(bus.o_phase), 0);
        chk_vec("rst_iv", 128'(bus.o_iv), '0);
        chk_vec("rst_aad", bus.o_aad, '0);
        chk_vec("rst_pt", bus.o_plain_text, '0);
        chk_vec("rst_len", bus.o_instance_size, '0);
        chk_int("rst_busy", int'(o_busy), 0);
        chk_int("rst_done", int'(o_done), 0);
        chk_int("rst_ready", int'(bus.o_blk_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_job("a1t2", 96'hCAFEBABE_FACEDBAD_DECAF888, 1, 2,
                {64'h80, 64'h100}, 1'b0, 1'b1, 0);
        run_job("a0t0", 96'h0123_4567_89AB_CDEF_0F1E_2D3C, 0, 0,
                128'h0, 1'b0, 1'b0, 0);
        run_job("a2t0_stall", 96'hFEED_F00D_1111_2222_3333_4444, 2, 0,
                {64'h100, 64'h0}, 1'b1, 1'b0, 1);

        // Abort mid-TEXT: block 2 of 4 is on the source when reset hits, so
        // only INIT and TEXT0 are sampled before the outputs clear.
        cur_iv = 96'hABCD_0000_1111_2222_3333_4444;
        sb.push_back(mk(P_INIT, cur_iv, '0, '0, '0));
        sb.push_back(mk(P_TEXT, cur_iv, '0, blk(0), '0));
        done0         = done_seen;
        i_start       = 1'b1;
        i_iv          = cur_iv;
        i_aad_blocks  = 16'd0;
        i_text_blocks = 16'd4;
        @(posedge clk); #1;
        i_start = 1'b0;
        sent    = 0;
        for (int n = 0; n < 2; n++) begin
            bus.i_blk_valid = 1'b1;
            bus.i_blk_data  = blk(sent);
            hs              = bus.o_blk_ready;
            @(posedge clk); #1;
            if (hs) sent++;
        end
        bus.i_blk_data = blk(sent);
        rst_n = 1'b0;
        @(negedge clk);
        chk_int("abort_valid", int'(bus.o_valid), 0);
        chk_int("abort_phase", int'(bus.o_phase), 0);
        chk_vec("abort_iv", 128'(bus.o_iv), '0);
        chk_vec("abort_pt", bus.o_plain_text, '0);
        chk_int("abort_busy", int'(o_busy), 0);
        chk_int("abort_ready", int'(bus.o_blk_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (PL + 4) @(posedge clk);
        #1;
        bus.i_blk_valid = 1'b0;
        chk_int("abort_no_done", done_seen - done0, 0);
        chk_int("abort_issues_left", sb.size(), 0);
        chk_int("abort_idle", int'(o_busy), 0);
        sb.delete();

        run_job("after_abort_a3t1", 96'h5555_AAAA_5555_AAAA_5555_AAAA, 3, 1,
                {64'h180, 64'h80}, 1'b0, 1'b0, 0);
        run_job("a0t65535", 96'h0000_0001_0000_0002_0000_0003, 0, 65535,
                {64'h0, 64'h7FFF80}, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
